// File: rtl/seg_display_scanner_pkg.sv
// seg_pkg: constants shared by the 7-segment scanner and its hex decoder.
//   AN_OFF / AN_PAT : digit-enable patterns (active-low, one-hot-zero)
//   SEG_BLANK       : all segments off (active-low)
//   SEG_TABLE       : hex nibble -> {g,f,e,d,c,b,a}, active-low
//   digit_idx_t     : digit index type (DIGIT_IDX_W bits)
package seg_pkg;

    localparam int DIGIT_IDX_W = 2;
    typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // AN_PAT[d] enables digit d; element 0 is the rightmost digit.
    localparam logic [3:0][3:0] AN_PAT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // SEG_TABLE[n] is the pattern for nibble n; listed F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_display_scanner_hex_to_seg7.sv
// hex_to_seg7: combinational hex-digit decoder.
//   nibble : 4-bit value to display
//   seg    : {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: frame-synchronous 4-digit common-anode 7-seg scanner.
//   CLK          : system clock
//   Reset        : asynchronous, active-low
//   data_i       : 16-bit word, nibble k -> digit k (digit0 rightmost)
//   dp_i         : decimal-point request per digit, active-high
//   data_valid_i : 1-cycle load strobe for data_i/dp_i
//   AN           : digit enables, active-low, one-hot-zero
//   Out          : segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_done_o : 1-cycle pulse after the edge that ends a frame
// Optional feature: define SEG_BLANK_LZ_EN for leading-zero blanking.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    input  logic        data_valid_i,
    output logic [3:0]  AN,
    output logic [7:0]  Out,
    output logic        frame_done_o
);

    logic [CNT_W-1:0] cnt;
    digit_idx_t       digit;
    logic [15:0]      pend_data;
    logic [3:0]       pend_dp;
    logic             pend_vld;
    logic [15:0]      disp_buf;
    logic [3:0]       dp_buf;

    logic             tick;
    logic             frame_end;
    logic [3:0]       cur_nib;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_nxt;
    logic [7:0]       out_nxt;

    always_comb begin
        tick      = (cnt == CNT_W'(SCAN_DIV - 1));
        frame_end = tick && (digit == digit_idx_t'(3));
        cur_nib   = disp_buf[{digit, 2'b00} +: 4];
    end

    hex_to_seg7 u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

`ifdef SEG_BLANK_LZ_EN
    logic upper_zero;

    // A digit is a leading zero when its nibble and every higher one are zero.
    always_comb begin
        upper_zero = ((disp_buf >> {digit, 2'b00}) == '0);
        seg_nxt    = dec_seg;
        if ((digit != '0) && upper_zero) begin
            seg_nxt = SEG_BLANK;
        end
    end
`else
    always_comb begin
        seg_nxt = dec_seg;
    end
`endif

    always_comb begin
        out_nxt = {~dp_buf[digit], seg_nxt};
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt   <= '0;
            digit <= '0;
        end else if (tick) begin
            cnt   <= '0;
            digit <= digit + digit_idx_t'(1);
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Output registers load the slot being entered; 'digit' names that slot.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            AN           <= AN_OFF;
            Out          <= '1;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= frame_end;
            if (tick) begin
                AN  <= AN_PAT[digit];
                Out <= out_nxt;
            end
        end
    end

    // A strobe coinciding with the frame boundary bypasses the pending regs.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_vld  <= 1'b0;
            disp_buf  <= '0;
            dp_buf    <= '0;
        end else if (frame_end) begin
            pend_vld <= 1'b0;
            if (data_valid_i) begin
                disp_buf <= data_i;
                dp_buf   <= dp_i;
            end else if (pend_vld) begin
                disp_buf <= pend_data;
                dp_buf   <= pend_dp;
            end
        end else if (data_valid_i) begin
            pend_data <= data_i;
            pend_dp   <= dp_i;
            pend_vld  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
module tb_seg_display_scanner;

    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 3;
    localparam int TMO      = 200;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] data_i = '0;
    logic [3:0]  dp_i = '0;
    logic        data_valid_i = 1'b0;
    logic [3:0]  AN;
    logic [7:0]  Out;
    logic        frame_done_o;

    seg_display_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .data_i       (data_i),
        .dp_i         (dp_i),
        .data_valid_i (data_valid_i),
        .AN           (AN),
        .Out          (Out),
        .frame_done_o (frame_done_o)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] out;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0]      data;
        logic [3:0]       dp;
        logic [3:0][7:0]  outs;   // outs[d] = expected Out for digit d
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef SEG_BLANK_LZ_EN
    localparam logic [3:0][7:0] ZERO_FRAME = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
`else
    localparam logic [3:0][7:0] ZERO_FRAME = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
    localparam logic [3:0][7:0] FRAME_2222 = {8'hA4, 8'hA4, 8'hA4, 8'hA4};
    localparam logic [3:0][7:0] FRAME_BEEF = {8'h03, 8'h86, 8'h06, 8'h8E};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scan monitor: every AN change is one tick and consumes one expectation.
    logic [3:0] prev_an = 4'hF;
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (Reset) begin
            if (AN !== prev_an) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick actual AN=%0h required no change", AN);
                end else begin
                    e = q.pop_front();
                    check("scan_an", 16'(AN), 16'(e.an));
                    check("scan_out", 16'(Out), 16'(e.out));
                    check("frame_done", 16'(frame_done_o), 16'(e.fd));
                end
            end else if (frame_done_o) begin
                check("frame_done_idle", 16'(frame_done_o), 16'd0);
            end
        end
        prev_an = AN;
    end

    task automatic push_frame(input logic [3:0][7:0] outs);
        for (int unsigned d = 0; d < 4; d++) begin
            exp_t e;
            e.an  = ~(4'b0001 << d);
            e.out = outs[d];
            e.fd  = (d == 3);
            q.push_back(e);
        end
    endtask

    task automatic wait_q(input int n);
        int t = 0;
        while (q.size() > n && t < TMO) begin
            @(negedge CLK);
            t++;
        end
        if (q.size() > n) begin
            checks++;
            errors++;
            $display("FAIL timeout_scan actual pending=%0d required=%0d", q.size(), n);
            q.delete();
        end
    endtask

    task automatic strobe(input logic [15:0] d, input logic [3:0] p);
        @(negedge CLK);
        data_i       = d;
        dp_i         = p;
        data_valid_i = 1'b1;
        @(negedge CLK);
        data_valid_i = 1'b0;
    endtask

    vec_t             vecs[8];
    logic [3:0][7:0]  cur;

    initial begin
        vecs[0] = '{16'h12AF, 4'b0001, {8'hF9, 8'hA4, 8'h88, 8'h0E}};
`ifdef SEG_BLANK_LZ_EN
        vecs[1] = '{16'h0042, 4'b0000, {8'hFF, 8'hFF, 8'h99, 8'hA4}};
        vecs[2] = '{16'h0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[4] = '{16'h0F00, 4'b0100, {8'hFF, 8'h0E, 8'hC0, 8'hC0}};
        vecs[5] = '{16'h0030, 4'b1000, {8'h7F, 8'hFF, 8'hB0, 8'hC0}};
`else
        vecs[1] = '{16'h0042, 4'b0000, {8'hC0, 8'hC0, 8'h99, 8'hA4}};
        vecs[2] = '{16'h0000, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[4] = '{16'h0F00, 4'b0100, {8'hC0, 8'h0E, 8'hC0, 8'hC0}};
        vecs[5] = '{16'h0030, 4'b1000, {8'h40, 8'hC0, 8'hB0, 8'hC0}};
`endif
        vecs[3] = '{16'h8000, 4'b1000, {8'h00, 8'hC0, 8'hC0, 8'hC0}};
        vecs[6] = '{16'h6B5D, 4'b0110, {8'h82, 8'h03, 8'h12, 8'hA1}};
        vecs[7] = '{16'h79CE, 4'b0000, {8'hF8, 8'h90, 8'hC6, 8'h86}};

        // Reset held, then released: dark until the first tick.
        #1 Reset = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_an", 16'(AN), 16'hF);
        check("rst_out", 16'(Out), 16'hFF);
        check("rst_fd", 16'(frame_done_o), 16'd0);
        Reset = 1'b1;
        cur = ZERO_FRAME;
        push_frame(cur);
        repeat (3) begin
            @(negedge CLK);
            check("pre_tick_an", 16'(AN), 16'hF);
            check("pre_tick_out", 16'(Out), 16'hFF);
        end

        // Table: strobe mid-frame; current frame keeps old data, next shows new.
        for (int unsigned i = 0; i < 8; i++) begin
            wait_q(2);
            strobe(vecs[i].data, vecs[i].dp);
            wait_q(0);
            cur = vecs[i].outs;
            push_frame(cur);
        end

        // Two strobes in one frame: last write wins.
        wait_q(3);
        strobe(16'h1111, 4'b1111);
        wait_q(1);
        strobe(16'h2222, 4'b0000);
        wait_q(0);
        cur = FRAME_2222;
        push_frame(cur);

        // Strobe exactly on the frame-boundary edge.
        wait_q(1);
        repeat (3) @(negedge CLK);
        data_i       = 16'hBEEF;
        dp_i         = 4'b1010;
        data_valid_i = 1'b1;
        @(negedge CLK);
        data_valid_i = 1'b0;
        wait_q(0);
        check("boundary_pend_vld", 16'(dut.pend_vld), 16'd0);
        cur = FRAME_BEEF;
        push_frame(cur);
        wait_q(0);
        push_frame(cur);

        // Reset while digit2 is lit with a word pending.
        wait_q(1);
        strobe(16'h5A5A, 4'b1111);
        Reset = 1'b0;
        #1;
        check("async_rst_an", 16'(AN), 16'hF);
        check("async_rst_out", 16'(Out), 16'hFF);
        check("async_rst_fd", 16'(frame_done_o), 16'd0);
        q.delete();
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        cur = ZERO_FRAME;
        push_frame(cur);
        repeat (3) begin
            @(negedge CLK);
            check("restart_an", 16'(AN), 16'hF);
        end
        wait_q(0);
        push_frame(cur);
        wait_q(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
